dispatch_queue: RTL
===================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter N, default 2, instructions per cycle in and out (1..8).
REQ-002 SHALL have parameter DEPTH, default 8, queue entries (power of two, >= 2*N).
REQ-003 SHALL have parameter NUM_BANKS, default 4, RS banks (ALU, MULT, BRANCH, MEM in order).
REQ-004 SHALL have parameter BANK_SZ, default 8, credits per bank.
REQ-005 SHALL have parameter PAYLOAD_W, default 64, opaque instruction payload bits.
REQ-006 SHALL define CW = $clog2(N+1) and BW = $clog2(NUM_BANKS).
REQ-007 clock  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 in_valid  in  N  lane mask from decode, contiguous from lane 0.
REQ-010 in_payload  in  N*PAYLOAD_W  per-lane payload.
REQ-011 in_bank  in  N*BW  per-lane target RS bank.
REQ-012 in_uses_rd  in  N  per-lane lane-needs-physical-register flag.
REQ-013 in_ready  out  1  queue accepts a full N-wide bundle this cycle.
REQ-014 rob_free  in  $clog2(DEPTH+1)  ROB free slots; values above N are treated as N.
REQ-015 fl_free  in  $clog2(DEPTH+1)  freelist free registers; values above N are treated as N.
REQ-016 bank_release  in  NUM_BANKS*CW  per-bank count of RS entries freed this cycle.
REQ-017 flush  in  1  mispredict squash of all queued instructions.
REQ-018 disp_valid  out  N  dispatched lanes, contiguous from lane 0.
REQ-019 disp_payload / disp_bank / disp_uses_rd  out  per lane  head entries in program order.
REQ-020 disp_count  out  CW  popcount of disp_valid.
REQ-021 occupancy  out  $clog2(DEPTH+1)  current entry count.
REQ-022 bank_credits  out  NUM_BANKS*$clog2(BANK_SZ+1)  current credit counters.

Function
REQ-023 SHALL store entries in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-024 in_ready SHALL be 1 iff DEPTH - occupancy >= N, evaluated from registered state only.
REQ-025 When in_ready=1, lanes with in_valid=1 SHALL be written at tail in lane order and tail SHALL advance by popcount(in_valid); when in_ready=0, input SHALL be ignored.
REQ-026 An enqueued entry SHALL become eligible for dispatch no earlier than the next cycle; there is no same-cycle bypass.
REQ-027 Lane k of the head window SHALL dispatch iff lane k-1 dispatched (k>0), k < occupancy, k < rob_free, the count of rd-users in lanes 0..k is <= fl_free, and the bank credit remaining after lanes 0..k-1 is >= 1.
REQ-028 The first blocked lane SHALL stop dispatch for all younger lanes in that cycle; no out-of-order dispatch.
REQ-029 Dispatch outputs SHALL be combinational from registered state and the rob_free, fl_free, and flush inputs.
REQ-030 Head SHALL advance by disp_count at the clock edge.
REQ-031 Each bank credit SHALL update as next = credit - dispatched_to_bank + bank_release[bank], with the release count saturating so that credit never exceeds BANK_SZ.
REQ-032 Credits SHALL never go below 0, which REQ-027 guarantees.
REQ-033 Simultaneous enqueue and dispatch SHALL update occupancy by +enq-disp in the same edge.
REQ-034 When flush=1, disp_valid SHALL be 0 that cycle, input SHALL be dropped, and head, tail, and occupancy SHALL be cleared at the edge.
REQ-035 flush SHALL NOT alter credits except by applying bank_release; the RS returns squashed entries via bank_release.
REQ-036 Empty queue: disp_valid=0. Full queue (occupancy=DEPTH): in_ready=0 and dispatch SHALL continue normally.

Reset
REQ-037 On reset=1 at a clock edge, head=tail=occupancy=0 and every credit=BANK_SZ; this has priority over flush, enqueue, and dispatch.
REQ-038 After reset, disp_valid=0, disp_count=0, and in_ready=1 (DEPTH>=N).
REQ-039 Reset asserted mid-operation SHALL discard all entries with no partial dispatch on that edge.

Verification (N=2, DEPTH=8, BANK_SZ=8)
REQ-040 Reset, enqueue 2 ALU (uses_rd=1), rob_free=fl_free=2 -> cycle+1: disp_valid=2'b11, disp_count=2, occupancy returns to 0, ALU credit=6.
REQ-041 Head lanes {ALU uses_rd, ALU uses_rd}, fl_free=1 -> disp_valid=2'b01; lane 1 dispatches the next cycle once fl_free>=1.
REQ-042 MULT credits drained to 0, head={MULT, ALU} -> disp_valid=0 (in-order block); a cycle with bank_release[MULT]=1 -> next cycle disp_valid>=2'b01, MULT credit goes 1->0.
REQ-043 Enqueue 4 bundles with rob_free=0 -> occupancy=8, in_ready=0, fifth bundle dropped; then rob_free=2 for 5 cycles -> entries drain in program order and pointers wrap correctly.
REQ-044 Occupancy 5 and flush=1 with concurrent in_valid=2'b11 -> disp_valid=0 that cycle, occupancy=0 next cycle, credits unchanged.
REQ-045 Reset asserted while occupancy=6 and ALU credit=3 -> next cycle occupancy=0, all credits=8, disp_valid=0.

Source files
------------

// File: rtl/dispatch_queue.sv
// N-wide in-order dispatch queue. A circular buffer feeds the reservation-station banks;
// each head lane is gated by ROB slots, free physical registers and per-bank RS credits.
module dispatch_queue #(
    parameter int N         = 2,
    parameter int DEPTH     = 8,
    parameter int NUM_BANKS = 4,
    parameter int BANK_SZ   = 8,
    parameter int PAYLOAD_W = 64,
    localparam int CW       = $clog2(N + 1),
    localparam int BW       = $clog2(NUM_BANKS),
    localparam int OW       = $clog2(DEPTH + 1),
    localparam int KW       = $clog2(BANK_SZ + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N-1:0]              in_valid,
    input  logic [N*PAYLOAD_W-1:0]    in_payload,
    input  logic [N*BW-1:0]           in_bank,
    input  logic [N-1:0]              in_uses_rd,
    output logic                      in_ready,
    input  logic [OW-1:0]             rob_free,
    input  logic [OW-1:0]             fl_free,
    input  logic [NUM_BANKS*CW-1:0]   bank_release,
    input  logic                      flush,
    output logic [N-1:0]              disp_valid,
    output logic [N*PAYLOAD_W-1:0]    disp_payload,
    output logic [N*BW-1:0]           disp_bank,
    output logic [N-1:0]              disp_uses_rd,
    output logic [CW-1:0]             disp_count,
    output logic [OW-1:0]             occupancy,
    output logic [NUM_BANKS*KW-1:0]   bank_credits
);

    localparam int PW = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0] mem_payload [DEPTH];
    logic [BW-1:0]        mem_bank    [DEPTH];
    logic                 mem_uses_rd [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [OW-1:0] occ;
    logic [KW-1:0] credit      [NUM_BANKS];
    logic [KW-1:0] credit_next [NUM_BANKS];
    logic [KW-1:0] used        [NUM_BANKS];

    logic [N-1:0]  enq_we;
    logic [PW-1:0] enq_idx [N];
    logic [CW-1:0] enq_count;

    logic          go;
    logic [BW-1:0] lane_bank;
    int unsigned   rd_cnt;
    int            credit_sum;

    assign occupancy = occ;
    assign in_ready  = (32'(occ) + 32'(N)) <= 32'(DEPTH);

    // Lanes are packed at tail in lane order; only the valid ones consume slots.
    always_comb begin
        enq_count = '0;
        for (int unsigned k = 0; k < N; k++) begin
            enq_we[k]  = in_ready && !flush && in_valid[k];
            enq_idx[k] = tail + PW'(enq_count);
            if (enq_we[k]) begin
                enq_count = enq_count + CW'(1);
            end
        end
    end

    // rob_free/fl_free above N need no clamp: k < N and rd_cnt <= N already bound them.
    always_comb begin
        disp_valid   = '0;
        disp_count   = '0;
        disp_payload = '0;
        disp_bank    = '0;
        disp_uses_rd = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            used[b] = '0;
        end
        go        = !flush;
        rd_cnt    = 0;
        lane_bank = '0;
        for (int unsigned k = 0; k < N; k++) begin
            lane_bank = mem_bank[head + PW'(k)];
            rd_cnt    = rd_cnt + 32'(mem_uses_rd[head + PW'(k)]);
            go = go && (k < 32'(occ)) && (k < 32'(rob_free)) &&
                 (rd_cnt <= 32'(fl_free)) && (credit[lane_bank] > used[lane_bank]);
            disp_valid[k] = go;
            if (go) begin
                used[lane_bank] = used[lane_bank] + KW'(1);
                disp_count      = disp_count + CW'(1);
            end
            disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = mem_payload[head + PW'(k)];
            disp_bank[k*BW +: BW]                  = lane_bank;
            disp_uses_rd[k]                        = mem_uses_rd[head + PW'(k)];
        end
    end

    always_comb begin
        bank_credits = '0;
        credit_sum   = 0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            credit_sum = int'(credit[b]) - int'(used[b]) + int'(bank_release[b*CW +: CW]);
            credit_next[b] = (credit_sum > BANK_SZ) ? KW'(BANK_SZ) : KW'(credit_sum);
            bank_credits[b*KW +: KW] = credit[b];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                credit[b] <= KW'(BANK_SZ);
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                credit[b] <= credit_next[b];
            end
            if (flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                head <= head + PW'(disp_count);
                tail <= tail + PW'(enq_count);
                occ  <= occ + OW'(enq_count) - OW'(disp_count);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < N; k++) begin
            if (enq_we[k] && !reset) begin
                mem_payload[enq_idx[k]] <= in_payload[k*PAYLOAD_W +: PAYLOAD_W];
                mem_bank[enq_idx[k]]    <= in_bank[k*BW +: BW];
                mem_uses_rd[enq_idx[k]] <= in_uses_rd[k];
            end
        end
    end

endmodule
